// File: rtl/cpu_pkg.sv
// Shared CPU constants: default datapath width, fetch queue depth and the
// canonical NOP (addi x0,x0,0) used wherever a pipeline bubble is inserted.
package cpu_pkg;
    localparam int          XLEN_DEF  = 32;
    localparam int          DEPTH_DEF = 4;
    localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
endpackage

// File: rtl/fq_ram.sv
// Fetch queue storage: one synchronous write port, one asynchronous read port.
// Deliberately has no reset; entry validity is tracked by the queue count.
module fq_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode. Entries appear one cycle
// after being pushed; flush (branch redirect) and reset empty the queue.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_ir,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_ir,
    output logic [XLEN-1:0]          out_pc,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop;
    logic [2*XLEN-1:0] rd_data;

    // Handshakes use only registered state, so there is no in-to-out path.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fq_ram #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_ram (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr_q),
        .wdata ({in_ir, in_pc}),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    // Empty queue presents a bubble to the decoder.
    assign out_ir = out_valid ? rd_data[2*XLEN-1:XLEN] : XLEN'(NOP_INSN);
    assign out_pc = out_valid ? rd_data[XLEN-1:0]      : '0;
    assign count  = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Scenario bench for fetch_queue: expected entries are queued as they are
// pushed and checked in order as the decoder side consumes them.
module tb_fetch_queue;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ir;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic [31:0] out_pc;
    logic        flush;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb [$];

    fetch_queue #(.XLEN(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ir     (in_ir),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ir    (out_ir),
        .out_pc    (out_pc),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Consumer-side scoreboard: a pop happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            logic [63:0] exp;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got ir=%h pc=%h, required no entry", out_ir, out_pc);
            end else begin
                exp = sb.pop_front();
                if ({out_ir, out_pc} !== exp) begin
                    bad++;
                    $display("FAIL pop_order: got ir=%h pc=%h, required ir=%h pc=%h",
                             out_ir, out_pc, exp[63:32], exp[31:0]);
                end else begin
                    $display("pop ir=%h pc=%h ok", out_ir, out_pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
    endtask

    // Push n entries with out_ready low; ir derived from pc.
    task automatic fill(input int n, input logic [31:0] pc0);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_pc    = pc0 + 32'(4 * i);
            in_ir    = 32'hA000_0000 | in_pc;
            sb.push_back({in_ir, in_pc});
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        in_ir = '0;
        in_pc = '0;
        tick();
        tick();
        total++;
        if ({count, out_valid, in_ready} !== {3'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_flags: got count=%0d ov=%b ir=%b, required 0 0 1", count, out_valid, in_ready);
        end
        total++;
        if (out_ir !== NOP || out_pc !== 32'd0) begin
            bad++;
            $display("FAIL reset_bubble: got ir=%h pc=%h, required %h 0", out_ir, out_pc, NOP);
        end
        rst = 1'b0;
        $display("reset done");
    endtask

    task automatic test_single_push();
        in_valid = 1'b1;
        in_ir    = 32'h0050_0093;
        in_pc    = 32'd0;
        sb.push_back({in_ir, in_pc});
        tick();
        in_valid = 1'b0;
        total++;
        if ({out_valid, out_ir, out_pc, count} !== {1'b1, 32'h0050_0093, 32'd0, 3'd1}) begin
            bad++;
            $display("FAIL single_push: got ov=%b ir=%h pc=%h count=%0d, required 1 00500093 0 1",
                     out_valid, out_ir, out_pc, count);
        end
        drain(1);
        total++;
        if (count !== 3'd0) begin
            bad++;
            $display("FAIL single_drain: got count=%0d, required 0", count);
        end
    endtask

    task automatic test_fill_drain();
        fill(4, 32'd0);
        total++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_flags: got count=%0d in_ready=%b, required 4 0", count, in_ready);
        end
        in_valid = 1'b1;
        in_pc    = 32'd16;
        in_ir    = 32'hDEAD_0010;
        tick();
        in_valid = 1'b0;
        total++;
        if (count !== 3'd4) begin
            bad++;
            $display("FAIL push_when_full: got count=%0d, required 4", count);
        end
        drain(4);
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_ir !== NOP) begin
            bad++;
            $display("FAIL drained: got count=%0d ov=%b ir=%h, required 0 0 %h", count, out_valid, out_ir, NOP);
        end
    endtask

    task automatic test_full_push_pop();
        fill(4, 32'd0);
        in_valid  = 1'b1;
        in_pc     = 32'd99;
        in_ir     = 32'hBAD0_0099;
        out_ready = 1'b1;
        tick();
        idle();
        total++;
        if (count !== 3'd3 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL full_push_pop: got count=%0d in_ready=%b, required 3 1", count, in_ready);
        end
        drain(3);
        total++;
        if (count !== 3'd0) begin
            bad++;
            $display("FAIL full_push_pop_drain: got count=%0d, required 0", count);
        end
    endtask

    task automatic test_back_to_back();
        fill(2, 32'h100);
        for (int i = 0; i < 6; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            in_pc     = 32'(16 + 4 * i);
            in_ir     = 32'hC000_0000 | in_pc;
            sb.push_back({in_ir, in_pc});
            tick();
            total++;
            if (count !== 3'd2) begin
                bad++;
                $display("FAIL b2b_count[%0d]: got count=%0d, required 2", i, count);
            end
        end
        idle();
        drain(2);
        total++;
        if (count !== 3'd0 || sb.size() != 0) begin
            bad++;
            $display("FAIL b2b_end: got count=%0d left=%0d, required 0 0", count, sb.size());
        end
    endtask

    task automatic test_flush();
        fill(3, 32'h200);
        in_valid  = 1'b1;
        in_pc     = 32'h2FC;
        in_ir     = 32'hF1F1_0000;
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        sb.delete();
        idle();
        total++;
        if ({count, out_valid, in_ready} !== {3'd0, 1'b0, 1'b1} || out_ir !== NOP || out_pc !== 32'd0) begin
            bad++;
            $display("FAIL flush: got count=%0d ov=%b ir_rdy=%b ir=%h pc=%h, required 0 0 1 %h 0",
                     count, out_valid, in_ready, out_ir, out_pc, NOP);
        end
        fill(1, 32'h300);
        total++;
        if (count !== 3'd1 || out_pc !== 32'h300) begin
            bad++;
            $display("FAIL post_flush: got count=%0d pc=%h, required 1 300", count, out_pc);
        end
        drain(1);
    endtask

    task automatic test_async_reset();
        fill(2, 32'h400);
        #2 rst = 1'b1;
        #1;
        sb.delete();
        total++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: got count=%0d ov=%b pc=%h in_ready=%b, required 0 0 0 1",
                     count, out_valid, out_pc, in_ready);
        end
        tick();
        rst = 1'b0;
        fill(1, 32'h500);
        total++;
        if (count !== 3'd1 || out_pc !== 32'h500) begin
            bad++;
            $display("FAIL first_push_after_reset: got count=%0d pc=%h, required 1 500", count, out_pc);
        end
        drain(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_push();
        test_fill_drain();
        test_full_push_pop();
        test_back_to_back();
        test_flush();
        test_async_reset();
        tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d entries, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32, instruction and PC width.
REQ-002 Parameter DEPTH, default 4, entry count; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  fetch presents an instruction.
REQ-006 in_ready  output  1  queue accepts; equals not-full, independent of out_ready.
REQ-007 in_ir  input  XLEN  fetched instruction word.
REQ-008 in_pc  input  XLEN  PC of in_ir.
REQ-009 out_valid  output  1  head entry available to decoder.
REQ-010 out_ready  input  1  decoder consumes the head this cycle.
REQ-011 out_ir  output  XLEN  head instruction; NOP 32'h00000013 when out_valid is 0.
REQ-012 out_pc  output  XLEN  head PC; 0 when out_valid is 0.
REQ-013 flush  input  1  branch redirect; discard all queued entries.
REQ-014 count  output  log2(DEPTH)+1  number of valid entries.

Function
REQ-015 Push occurs when in_valid and in_ready are both 1 at a rising edge; entry written at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-016 Pop occurs when out_valid and out_ready are both 1 at a rising edge; rd_ptr increments modulo DEPTH.
REQ-017 Latency: an entry pushed at edge N appears on out_* in the cycle after edge N (one cycle); no combinational in-to-out bypass.
REQ-018 out_ir/out_pc are driven from storage at rd_ptr, gated to NOP/0 when count is 0.
REQ-019 Push and pop in the same cycle: count unchanged, both pointers advance; permitted when full (pop side) since in_ready reflects pre-edge state, so no push when full.
REQ-020 Pop with count 0 is impossible (out_valid 0); push with count DEPTH is impossible (in_ready 0).
REQ-021 Pointer wrap: after DEPTH pushes wr_ptr returns to 0; ordering preserved across wrap.
REQ-022 flush has priority over push and pop: at the edge where flush is 1, count, wr_ptr, rd_ptr become 0 and any simultaneous push or pop is discarded.
REQ-023 In the cycle after a flush, out_valid is 0, out_ir is NOP, in_ready is 1.
REQ-024 count = entries pushed minus popped since last reset/flush, range 0..DEPTH.
REQ-025 Storage contents are not cleared by flush or reset; validity tracked solely by count.

Reset
REQ-026 While rst is 1: count 0, wr_ptr 0, rd_ptr 0, out_valid 0, out_ir 32'h00000013, out_pc 0, in_ready 1.
REQ-027 Reset asserted mid-operation discards all entries immediately, independent of clk.
REQ-028 First push is accepted at the first rising edge after rst deasserts.

Structure
REQ-029 XLEN default, DEPTH default, and the NOP encoding 32'h00000013 shall be constants in the shared cpu package, also used by decoder bubble insertion.
REQ-030 Storage array shall be one sub-module fq_ram: DEPTH x (2*XLEN), one synchronous write port, one asynchronous read port, no reset.
REQ-031 Pointer/count control stays in fetch_queue; no other sub-modules.

Verification
REQ-032 Reset then push ir=32'h00500093 pc=0 -> next cycle out_valid 1, out_ir 32'h00500093, out_pc 0, count 1.
REQ-033 out_ready 0, push 4 entries pc=0,4,8,12 -> count 4, in_ready 0; fifth in_valid ignored; then drain -> pcs 0,4,8,12 in order.
REQ-034 Full queue, in_valid 1 and out_ready 1 for one edge -> pc 0 popped, no push, count 3, in_ready 1.
REQ-035 count 2, simultaneous push and pop for 6 cycles with pc 16..36 -> count stays 2, wrap-around output order correct.
REQ-036 count 3, flush 1 with in_valid 1 and out_ready 1 -> next cycle count 0, out_valid 0, out_ir 32'h00000013, pushed entry absent.
REQ-037 count 2, rst pulsed between edges -> immediately count 0, out_valid 0, out_pc 0.
